// File: rtl/oai22_pattern_driver_if.sv
// Drive/response bundle between the OAI22 pattern driver and the cell under test.
// The master modport is the driver side; the slave modport is the cell/controller side.
interface oai22_pattern_driver_if;
    logic       start;
    logic       abort;
    logic       resp_y;
    logic       stim_a;
    logic       stim_b;
    logic       stim_c;
    logic       stim_d;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic       first_fail_valid;
    logic [3:0] first_fail_vec;

    modport master (
        input  start, abort, resp_y,
        output stim_a, stim_b, stim_c, stim_d, busy, done, pass,
               err_count, first_fail_valid, first_fail_vec
    );

    modport slave (
        output start, abort, resp_y,
        input  stim_a, stim_b, stim_c, stim_d, busy, done, pass,
               err_count, first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/oai22_pattern_driver.sv
// Walks all 16 A/B/C/D vectors through an OAI22 cell, waits a settle window per
// vector, and scores the returned Y against ~((A|B)&(C|D)).
module oai22_pattern_driver #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    oai22_pattern_driver_if.master bus
);
    localparam int unsigned VEC_W    = 4;
    localparam int unsigned ERR_W    = 5;
    localparam int unsigned SETTLE_W = 8;
    localparam logic [SETTLE_W-1:0] SETTLE_RELOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0]    LAST_VEC      = VEC_W'(15);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    state_t              state_q, state_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [VEC_W-1:0]    stim_q, stim_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                ffv_q, ffv_d;
    logic [VEC_W-1:0]    ffvec_q, ffvec_d;
    logic                exp_y_c;
    logic                mismatch_c;

    assign exp_y_c    = ~((vec_q[3] | vec_q[2]) & (vec_q[1] | vec_q[0]));
    assign mismatch_c = (bus.resp_y != exp_y_c);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            stim_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            stim_q   <= stim_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            ffv_q    <= ffv_d;
            ffvec_q  <= ffvec_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        stim_d   = stim_q;
        pass_d   = pass_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffvec_d  = ffvec_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    err_d    = '0;
                    ffv_d    = 1'b0;
                    ffvec_d  = '0;
                    pass_d   = 1'b0;
                    vec_d    = '0;
                    settle_d = SETTLE_RELOAD;
                    state_d  = APPLY;
                end
            end
            APPLY: begin
                if (bus.abort) begin
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end else if (settle_q != '0) begin
                    settle_d = settle_q - SETTLE_W'(1);
                end else begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (bus.abort) begin
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (mismatch_c) begin
                        err_d = err_q + ERR_W'(1);
                        if (!ffv_q) begin
                            ffv_d   = 1'b1;
                            ffvec_d = vec_q;
                        end
                    end
                    if (vec_q == LAST_VEC) begin
                        pass_d  = (err_d == '0);
                        state_d = DONE;
                    end else begin
                        vec_d    = vec_q + VEC_W'(1);
                        settle_d = SETTLE_RELOAD;
                        stim_d   = vec_q + VEC_W'(1);
                        state_d  = APPLY;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Stimulus is parked at zero whenever no vector is being applied
        if (state_d == IDLE || state_d == DONE) begin
            stim_d = '0;
        end
        busy_d = (state_d == APPLY) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
    end

    assign bus.stim_a           = stim_q[3];
    assign bus.stim_b           = stim_q[2];
    assign bus.stim_c           = stim_q[1];
    assign bus.stim_d           = stim_q[0];
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;
endmodule

// File: doc/oai22_pattern_driver.md
# oai22_pattern_driver

Sequential stimulus/response engine that drives the four inputs of a 4-input OAI22-type cell under test and checks its output. It applies all 16 input vectors in a fixed order, waits a programmable settle window per vector, samples the returned Y, and compares it against the expected function Y = ~((A|B)&(C|D)). It sits on the cell-characterization/bring-up side of the library flow and is the driving end of the cell's A/B/C/D → Y interface.

## Interface
Parameters:
- SETTLE_CYCLES, 2: cycles each vector is held before Y is sampled; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  one-cycle request to begin a run; honoured only in IDLE.
- abort  input  1  stops a run in progress; returns to IDLE.
- resp_y  input  1  Y returned from the cell under test; treated as synchronous to clk.
- stim_a, stim_b, stim_c, stim_d  output  1 each  registered drive to cell inputs A, B, C, D.
- busy  output  1  high from the first APPLY cycle through the last SAMPLE cycle.
- done  output  1  one-cycle pulse when a run completes normally.
- pass  output  1  high when the last completed run had zero mismatches; held until the next start.
- err_count  output  5  mismatch count of the current/last run, 0..16.
- first_fail_valid  output  1  high once any mismatch has been seen in the current/last run.
- first_fail_vec  output  4  {A,B,C,D} of the first mismatching vector.

## Operation
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE: stim = 0, busy = 0. On start: clear err_count, first_fail_valid, first_fail_vec and pass; load vec = 0, settle = SETTLE_CYCLES-1; go to APPLY.
- Vector mapping: {stim_a, stim_b, stim_c, stim_d} = vec[3:0], with vec[3] driving A. Vectors are applied in ascending order 0..15.
- APPLY: hold stim. If settle != 0, decrement it. If settle == 0, go to SAMPLE.
- SAMPLE (one cycle per vector): compare resp_y against exp = ~((vec[3]|vec[2]) & (vec[1]|vec[0])).
  - On mismatch: err_count += 1. If first_fail_valid = 0, capture first_fail_vec = vec and set first_fail_valid.
  - If vec == 15, go to DONE. Otherwise vec += 1, reload settle, and return to APPLY.
  - The vec increment never wraps, because exit happens at 15.
- DONE (one cycle): done = 1, pass = (err_count == 0), stim returns to 0; next state is IDLE.
- abort in APPLY or SAMPLE: next cycle is IDLE. The mismatch in progress is not counted; no done pulse; pass = 0; err_count and first_fail_* keep their values.
- abort has priority over start. start while busy or in DONE is ignored.
- abort and rst_n are independent; rst_n wins.
- err_count width: the maximum is 16, so there is no saturation logic.

## Timing
- Reset value of every output is 0: stim_*, busy, done, pass, err_count, first_fail_valid, first_fail_vec. State resets to IDLE.
- Reset asserted mid-run returns to IDLE on that edge, with no done pulse.
- start sampled high at edge t: busy = 1 and stim = 0000 from t+1.
- Each vector occupies SETTLE_CYCLES APPLY cycles plus 1 SAMPLE cycle. Stim changes only on the edge entering the first APPLY cycle of a vector.
- resp_y is sampled SETTLE_CYCLES cycles after stim changes, so the cell-plus-return-path latency must be ≤ SETTLE_CYCLES cycles.
- A full run takes 16·(SETTLE_CYCLES+1) busy cycles. done pulses on the next cycle, and a new start is accepted the cycle after that.
- err_count and first_fail_* update on the edge after the SAMPLE cycle and are stable when done is asserted.

## Test plan
- Ideal cell (combinational model on stim), SETTLE_CYCLES=2, start at t → busy for 48 cycles, done at t+49, pass=1, err_count=0, first_fail_valid=0.
- resp_y stuck at 1 → err_count=9, first_fail_vec=4'b0101, pass=0.
- resp_y stuck at 0 → err_count=7, first_fail_vec=4'b0000, pass=0.
- Cell model with 3-cycle response delay and SETTLE_CYCLES=1 → err_count≠0 and pass=0. Same model with SETTLE_CYCLES=3 → pass=1.
- abort during vector 6, then start again → no done on the abort, IDLE on the next cycle, stim=0, pass=0. The second run completes normally with pass=1.
- rst_n low during vector 9 → all outputs 0 on the next edge. start pressed while busy (before the reset) has no effect on the vector sequence.
